// File: rtl/mem_lsu_pkg.sv
// mem_lsu_pkg: shared definitions for the MEM-stage load/store unit.
// Holds the memory operation codes, bus width constants, the FSM state
// encoding and small decode helpers used by mem_lsu and mem_lsu_align.
package mem_lsu_pkg;

    localparam int WORD_W = 32;
    localparam logic [WORD_W-1:0] ZERO_WORD = 32'h0000_0000;

    localparam logic [7:0] OP_LB  = 8'b1110_0000;
    localparam logic [7:0] OP_LBU = 8'b1110_0100;
    localparam logic [7:0] OP_LH  = 8'b1110_0001;
    localparam logic [7:0] OP_LHU = 8'b1110_0101;
    localparam logic [7:0] OP_LW  = 8'b1110_0011;
    localparam logic [7:0] OP_SB  = 8'b1110_1000;
    localparam logic [7:0] OP_SH  = 8'b1110_1001;
    localparam logic [7:0] OP_SW  = 8'b1110_1011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } lsu_state_e;

    function automatic logic is_mem_op(input logic [7:0] op);
        case (op)
            OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW,
            OP_SB, OP_SH, OP_SW: is_mem_op = 1'b1;
            default:             is_mem_op = 1'b0;
        endcase
    endfunction

    function automatic logic is_load(input logic [7:0] op);
        case (op)
            OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW: is_load = 1'b1;
            default:                             is_load = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_lsu_align.sv
// mem_lsu_align: combinational byte-lane steering for the load/store unit.
// Big-endian lanes: addr_lo=00 selects bits [31:24].
//   aluop     in  8   operation code
//   addr_lo   in  2   low address bits
//   reg2      in  32  store data
//   rdata     in  32  latched read data
//   sel       out 4   byte-lane enables (bit3 = [31:24])
//   wdata     out 32  lane-replicated store data (0 for non-stores)
//   load_data out 32  aligned, extended load result (0 for non-loads)
module mem_lsu_align
    import mem_lsu_pkg::*;
(
    input  logic [7:0]        aluop,
    input  logic [1:0]        addr_lo,
    input  logic [WORD_W-1:0] reg2,
    input  logic [WORD_W-1:0] rdata,
    output logic [3:0]        sel,
    output logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] load_data
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;
    logic [3:0]  byte_sel_s;
    logic [3:0]  half_sel_s;

    // Pick the addressed byte lane and its one-hot enable.
    always_comb begin
        byte_s     = rdata[31:24];
        byte_sel_s = 4'b1000;
        case (addr_lo)
            2'b00:   begin byte_s = rdata[31:24]; byte_sel_s = 4'b1000; end
            2'b01:   begin byte_s = rdata[23:16]; byte_sel_s = 4'b0100; end
            2'b10:   begin byte_s = rdata[15:8];  byte_sel_s = 4'b0010; end
            2'b11:   begin byte_s = rdata[7:0];   byte_sel_s = 4'b0001; end
            default: begin byte_s = rdata[31:24]; byte_sel_s = 4'b1000; end
        endcase
    end

    // Pick the addressed halfword; addr_lo[0] is ignored.
    always_comb begin
        if (addr_lo[1]) begin
            half_s     = rdata[15:0];
            half_sel_s = 4'b0011;
        end else begin
            half_s     = rdata[31:16];
            half_sel_s = 4'b1100;
        end
    end

    // Per-operation lane enables, store replication and load extension.
    always_comb begin
        sel       = 4'b0000;
        wdata     = ZERO_WORD;
        load_data = ZERO_WORD;
        case (aluop)
            OP_LB:  begin sel = byte_sel_s; load_data = {{24{byte_s[7]}}, byte_s}; end
            OP_LBU: begin sel = byte_sel_s; load_data = {24'h00_0000, byte_s}; end
            OP_LH:  begin sel = half_sel_s; load_data = {{16{half_s[15]}}, half_s}; end
            OP_LHU: begin sel = half_sel_s; load_data = {16'h0000, half_s}; end
            OP_LW:  begin sel = 4'b1111;    load_data = rdata; end
            OP_SB:  begin sel = byte_sel_s; wdata = {4{reg2[7:0]}}; end
            OP_SH:  begin sel = half_sel_s; wdata = {2{reg2[15:0]}}; end
            OP_SW:  begin sel = 4'b1111;    wdata = reg2; end
            default: begin
                sel       = 4'b0000;
                wdata     = ZERO_WORD;
                load_data = ZERO_WORD;
            end
        endcase
    end

endmodule

// File: rtl/mem_lsu.sv
// mem_lsu: MEM stage of the 5-stage MIPS32 pipeline. Non-memory ops pass
// straight through; loads/stores run one req/ack bus transaction while
// stallreq holds the pipeline.
//   clk, rst (sync, active-high)
//   ex_*        in   values from ex_mem
//   mem_*       out  values toward mem_wb
//   stallreq    out  stall request to ctrl
//   bus_req/we/addr/sel/wdata  out  registered bus request
//   bus_rdata, bus_ack         in   slave response
//   bus_timeout out  one-cycle pulse when a transaction is abandoned
module mem_lsu
    import mem_lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [4:0]        ex_wd,
    input  logic              ex_wreg,
    input  logic [WORD_W-1:0] ex_wdata,
    input  logic [WORD_W-1:0] ex_hi,
    input  logic [WORD_W-1:0] ex_lo,
    input  logic              ex_whilo,
    input  logic [7:0]        ex_aluop,
    input  logic [WORD_W-1:0] ex_mem_addr,
    input  logic [WORD_W-1:0] ex_reg2,
    output logic [4:0]        mem_wd,
    output logic              mem_wreg,
    output logic [WORD_W-1:0] mem_wdata,
    output logic [WORD_W-1:0] mem_hi,
    output logic [WORD_W-1:0] mem_lo,
    output logic              mem_whilo,
    output logic              stallreq,
    output logic              bus_req,
    output logic              bus_we,
    output logic [WORD_W-1:0] bus_addr,
    output logic [3:0]        bus_sel,
    output logic [WORD_W-1:0] bus_wdata,
    input  logic [WORD_W-1:0] bus_rdata,
    input  logic              bus_ack,
    output logic              bus_timeout
);

    // TIMEOUT=0 wraps this to all-ones, but the compare is gated off then.
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 32'd1);

    lsu_state_e        state_r;
    lsu_state_e        state_nxt_s;
    logic [15:0]       cnt_r;
    logic [WORD_W-1:0] rdata_r;
    logic              timed_out_r;
    logic              mem_op_s;
    logic              load_s;
    logic              timeout_hit_s;
    logic [3:0]        sel_s;
    logic [WORD_W-1:0] wdata_s;
    logic [WORD_W-1:0] load_data_s;

    assign mem_op_s      = is_mem_op(ex_aluop);
    assign load_s        = is_load(ex_aluop);
    assign timeout_hit_s = (TIMEOUT != 32'd0) && (cnt_r == TIMEOUT_LAST);

    // ex_mem is held during the stall, so the same aluop/address drive both
    // the request lanes and the DONE-cycle load extension.
    mem_lsu_align u_align (
        .aluop     (ex_aluop),
        .addr_lo   (ex_mem_addr[1:0]),
        .reg2      (ex_reg2),
        .rdata     (rdata_r),
        .sel       (sel_s),
        .wdata     (wdata_s),
        .load_data (load_data_s)
    );

    assign mem_wd    = ex_wd;
    assign mem_hi    = ex_hi;
    assign mem_lo    = ex_lo;
    assign mem_whilo = ex_whilo;

    // Next-state logic for the transaction FSM.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (mem_op_s) state_nxt_s = ST_BUSY;
                else          state_nxt_s = ST_IDLE;
            end
            ST_BUSY: begin
                if (bus_ack || timeout_hit_s) state_nxt_s = ST_DONE;
                else                          state_nxt_s = ST_BUSY;
            end
            ST_DONE: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Stall request and pass-through / load-result selection toward mem_wb.
    always_comb begin
        stallreq  = 1'b0;
        mem_wdata = ex_wdata;
        mem_wreg  = ex_wreg;
        if (rst) begin
            stallreq  = 1'b0;
            mem_wdata = ex_wdata;
            mem_wreg  = ex_wreg;
        end else begin
            case (state_r)
                ST_IDLE: stallreq = mem_op_s;
                ST_BUSY: stallreq = 1'b1;
                ST_DONE: begin
                    stallreq = 1'b0;
                    if (load_s) begin
                        mem_wdata = load_data_s;
                        mem_wreg  = ex_wreg & ~timed_out_r;
                    end else begin
                        mem_wdata = ex_wdata;
                        mem_wreg  = ex_wreg;
                    end
                end
                default: stallreq = 1'b0;
            endcase
        end
    end

    // State, bus request registers, wait counter and read-data latch.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            cnt_r       <= 16'd0;
            rdata_r     <= ZERO_WORD;
            timed_out_r <= 1'b0;
            bus_req     <= 1'b0;
            bus_we      <= 1'b0;
            bus_addr    <= ZERO_WORD;
            bus_sel     <= 4'b0000;
            bus_wdata   <= ZERO_WORD;
            bus_timeout <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            bus_timeout <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (mem_op_s) begin
                        bus_req     <= 1'b1;
                        bus_we      <= ~load_s;
                        bus_addr    <= {ex_mem_addr[31:2], 2'b00};
                        bus_sel     <= sel_s;
                        bus_wdata   <= wdata_s;
                        cnt_r       <= 16'd0;
                        timed_out_r <= 1'b0;
                    end else begin
                        bus_req <= 1'b0;
                    end
                end
                ST_BUSY: begin
                    cnt_r <= cnt_r + 16'd1;
                    if (bus_ack) begin
                        bus_req <= 1'b0;
                        rdata_r <= bus_rdata;
                    end else if (timeout_hit_s) begin
                        bus_req     <= 1'b0;
                        bus_timeout <= 1'b1;
                        rdata_r     <= ZERO_WORD;
                        timed_out_r <= 1'b1;
                    end else begin
                        bus_req <= 1'b1;
                    end
                end
                ST_DONE: bus_req <= 1'b0;
                default: bus_req <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_lsu.sv
module tb_mem_lsu;

    localparam int TO = 4;

    localparam logic [7:0] LB  = 8'hE0;
    localparam logic [7:0] LBU = 8'hE4;
    localparam logic [7:0] LH  = 8'hE1;
    localparam logic [7:0] LHU = 8'hE5;
    localparam logic [7:0] LW  = 8'hE3;
    localparam logic [7:0] SB  = 8'hE8;
    localparam logic [7:0] SH  = 8'hE9;
    localparam logic [7:0] SW  = 8'hEB;
    localparam logic [7:0] ADDU = 8'h21;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  ex_wd;
    logic        ex_wreg;
    logic [31:0] ex_wdata, ex_hi, ex_lo;
    logic        ex_whilo;
    logic [7:0]  ex_aluop;
    logic [31:0] ex_mem_addr, ex_reg2;
    logic [4:0]  mem_wd;
    logic        mem_wreg;
    logic [31:0] mem_wdata, mem_hi, mem_lo;
    logic        mem_whilo, stallreq, bus_req, bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_sel;
    logic [31:0] bus_wdata, bus_rdata;
    logic        bus_ack, bus_timeout;

    mem_lsu #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata),
        .ex_hi(ex_hi), .ex_lo(ex_lo), .ex_whilo(ex_whilo),
        .ex_aluop(ex_aluop), .ex_mem_addr(ex_mem_addr), .ex_reg2(ex_reg2),
        .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
        .mem_hi(mem_hi), .mem_lo(mem_lo), .mem_whilo(mem_whilo),
        .stallreq(stallreq),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_sel(bus_sel), .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata), .bus_ack(bus_ack), .bus_timeout(bus_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] wdata;
        logic        wreg;
        logic [4:0]  wd;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        whilo;
        int          stall;
        logic        to;
    } out_exp_t;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  sel;
        logic        we;
        logic [31:0] wdata;
        bit          chk_wdata;
    } bus_exp_t;

    out_exp_t out_q[$];
    bus_exp_t bus_q[$];

    int n_vec  = 0;
    int n_fail = 0;
    bit mon_en = 1'b0;
    bit slave_en = 1'b0;
    int slave_wait = 0;
    bit slave_noack = 1'b0;
    logic [31:0] slave_rdata = 32'h0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_vec++;
        n_fail++;
        $display("FAIL %s: got event, expected none", name);
    endtask

    // ---------------- reference model ----------------
    function automatic bit ref_is_mem(input logic [7:0] op);
        return (op == LB) || (op == LBU) || (op == LH) || (op == LHU) || (op == LW) ||
               (op == SB) || (op == SH) || (op == SW);
    endfunction

    function automatic bit ref_is_load(input logic [7:0] op);
        return (op == LB) || (op == LBU) || (op == LH) || (op == LHU) || (op == LW);
    endfunction

    function automatic int ref_size(input logic [7:0] op);
        if (op == LB || op == LBU || op == SB) return 1;
        if (op == LH || op == LHU || op == SH) return 2;
        return 4;
    endfunction

    function automatic logic [3:0] ref_sel(input logic [7:0] op, input logic [31:0] a);
        logic [3:0] b = 4'b1000;
        logic [3:0] h = 4'b1100;
        case (ref_size(op))
            1:       return b >> a[1:0];
            2:       return h >> (2 * a[1]);
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [7:0] op, input logic [31:0] r);
        case (ref_size(op))
            1:       return (r & 32'hFF) * 32'h0101_0101;
            2:       return (r & 32'hFFFF) * 32'h0001_0001;
            default: return r;
        endcase
    endfunction

    function automatic logic [31:0] ref_load(input logic [7:0] op, input logic [31:0] a, input logic [31:0] d);
        logic [31:0] bv, hv;
        bv = (d >> (8 * (3 - a[1:0]))) & 32'hFF;
        hv = (d >> (16 * (1 - a[1]))) & 32'hFFFF;
        case (op)
            LB:      return (bv >= 32'd128) ? (bv | 32'hFFFF_FF00) : bv;
            LBU:     return bv;
            LH:      return (hv >= 32'd32768) ? (hv | 32'hFFFF_0000) : hv;
            LHU:     return hv;
            default: return d;
        endcase
    endfunction

    // ---------------- bus slave ----------------
    initial begin
        int seen;
        seen = 0;
        bus_ack = 1'b0;
        bus_rdata = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            if (slave_en) begin
                if (bus_req) begin
                    seen++;
                    if (!slave_noack && seen == slave_wait + 1) begin
                        bus_ack = 1'b1;
                        bus_rdata = slave_rdata;
                    end else begin
                        bus_ack = 1'b0;
                        bus_rdata = $urandom;
                    end
                end else begin
                    seen = 0;
                    bus_ack = 1'b0;
                    bus_rdata = $urandom;
                end
            end
        end
    end

    // ---------------- monitor ----------------
    initial begin
        int stall_run;
        bit prev_req;
        out_exp_t e;
        bus_exp_t b;
        stall_run = 0;
        prev_req = 1'b0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (bus_req && !prev_req) begin
                    if (bus_q.size() == 0) begin
                        fail_now("bus_req_unexpected");
                    end else begin
                        b = bus_q.pop_front();
                        check("bus_addr", bus_addr, b.addr);
                        check("bus_sel", {28'h0, bus_sel}, {28'h0, b.sel});
                        check("bus_we", {31'h0, bus_we}, {31'h0, b.we});
                        if (b.chk_wdata) check("bus_wdata", bus_wdata, b.wdata);
                    end
                end
                prev_req = bus_req;
                if (stallreq) begin
                    stall_run++;
                end else if (out_q.size() == 0) begin
                    fail_now("output_unexpected");
                end else begin
                    e = out_q.pop_front();
                    check("mem_wdata", mem_wdata, e.wdata);
                    check("mem_wreg", {31'h0, mem_wreg}, {31'h0, e.wreg});
                    check("mem_wd", {27'h0, mem_wd}, {27'h0, e.wd});
                    check("mem_hi", mem_hi, e.hi);
                    check("mem_lo", mem_lo, e.lo);
                    check("mem_whilo", {31'h0, mem_whilo}, {31'h0, e.whilo});
                    check("stall_cycles", stall_run, e.stall);
                    check("bus_timeout", {31'h0, bus_timeout}, {31'h0, e.to});
                    stall_run = 0;
                end
            end else begin
                stall_run = 0;
                prev_req = bus_req;
            end
        end
    end

    // ---------------- driver ----------------
    task automatic issue(input logic [7:0] op, input logic [31:0] wdata, input logic wreg,
                         input logic [4:0] wd, input logic [31:0] addr, input logic [31:0] reg2,
                         input int wt, input bit noack, input logic [31:0] rdata);
        out_exp_t e;
        bus_exp_t b;
        bit mem, ld, acked, adv;
        int budget;
        mem = ref_is_mem(op);
        ld = ref_is_load(op);
        acked = !noack && (wt < TO);
        e.wd = wd;
        e.hi = $urandom;
        e.lo = $urandom;
        e.whilo = 1'($urandom_range(0, 1));
        if (!mem) begin
            e.stall = 0;
            e.to = 1'b0;
            e.wdata = wdata;
            e.wreg = wreg;
        end else begin
            e.stall = acked ? wt + 2 : TO + 1;
            e.to = !acked;
            if (ld) begin
                e.wdata = acked ? ref_load(op, addr, rdata) : 32'h0;
                e.wreg = acked ? wreg : 1'b0;
            end else begin
                e.wdata = wdata;
                e.wreg = wreg;
            end
            b.addr = addr & 32'hFFFF_FFFC;
            b.sel = ref_sel(op, addr);
            b.we = !ld;
            b.wdata = ref_wdata(op, reg2);
            b.chk_wdata = !ld;
            bus_q.push_back(b);
        end
        out_q.push_back(e);
        slave_wait = wt;
        slave_noack = noack;
        slave_rdata = rdata;
        ex_aluop = op;
        ex_wdata = wdata;
        ex_wreg = wreg;
        ex_wd = wd;
        ex_mem_addr = addr;
        ex_reg2 = reg2;
        ex_hi = e.hi;
        ex_lo = e.lo;
        ex_whilo = e.whilo;
        budget = 0;
        forever begin
            @(negedge clk);
            adv = !stallreq;
            @(posedge clk);
            #1;
            budget++;
            if (adv) break;
            if (budget > 20) begin
                fail_now("advance_timeout");
                break;
            end
        end
    endtask

    initial begin
        logic [7:0] mem_ops[8];
        logic [7:0] op;
        int r;
        mem_ops = '{LB, LBU, LH, LHU, LW, SB, SH, SW};
        rst = 1'b1;
        ex_aluop = ADDU; ex_wdata = 32'h1111_2222; ex_wreg = 1'b1; ex_wd = 5'd3;
        ex_hi = 32'h0; ex_lo = 32'h0; ex_whilo = 1'b0;
        ex_mem_addr = 32'h0; ex_reg2 = 32'h0;
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_stallreq", {31'h0, stallreq}, 32'h0);
        check("rst_passthru", mem_wdata, 32'h1111_2222);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_bus_req", {31'h0, bus_req}, 32'h0);
        check("rst_bus_addr", bus_addr, 32'h0);
        check("rst_bus_sel", {28'h0, bus_sel}, 32'h0);
        check("rst_bus_wdata", bus_wdata, 32'h0);
        check("rst_bus_we", {31'h0, bus_we}, 32'h0);
        check("rst_bus_timeout", {31'h0, bus_timeout}, 32'h0);
        @(posedge clk); #1;
        slave_en = 1'b1;
        mon_en = 1'b1;

        // directed cases
        issue(ADDU, 32'h1234_5678, 1'b1, 5'd5, 32'h0, 32'h0, 0, 1'b0, 32'h0);
        issue(LB, 32'h0, 1'b1, 5'd6, 32'h0000_0103, 32'h0, 0, 1'b0, 32'hAABB_CC80);
        issue(LHU, 32'h0, 1'b1, 5'd7, 32'h0000_0002, 32'h0, 3, 1'b0, 32'h1234_F00D);
        issue(SB, 32'h5555_0000, 1'b0, 5'd8, 32'h0000_0001, 32'h0000_00A5, 0, 1'b0, 32'h0);
        issue(LW, 32'h7777_7777, 1'b1, 5'd9, 32'h0000_0010, 32'h0, 0, 1'b1, 32'h0);
        issue(SW, 32'h0, 1'b0, 5'd1, 32'h0000_0203, 32'hDEAD_BEEF, 1, 1'b0, 32'h0);
        issue(LH, 32'h0, 1'b1, 5'd2, 32'h0000_0000, 32'h0, 2, 1'b0, 32'h8001_7FFF);

        // randomized traffic
        for (int i = 0; i < 150; i++) begin
            r = $urandom_range(0, 11);
            if (r < 8) begin
                op = mem_ops[r];
            end else begin
                op = 8'($urandom);
                if (ref_is_mem(op)) op = ADDU;
            end
            issue(op, $urandom, 1'($urandom_range(0, 1)), 5'($urandom), $urandom, $urandom,
                  $urandom_range(0, 3), ($urandom_range(0, 7) == 0), $urandom);
        end

        mon_en = 1'b0;
        check("queues_drained", out_q.size() + bus_q.size(), 32'h0);

        // reset while a load is in flight, followed by a late ack
        slave_en = 1'b0;
        bus_ack = 1'b0;
        ex_aluop = LW; ex_mem_addr = 32'h0000_0040; ex_wdata = 32'h0; ex_wreg = 1'b1;
        @(negedge clk);
        check("rstbusy_idle_stall", {31'h0, stallreq}, 32'h1);
        @(posedge clk); #1;
        @(negedge clk);
        check("rstbusy_req_open", {31'h0, bus_req}, 32'h1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("rstbusy_stall_in_rst", {31'h0, stallreq}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        ex_aluop = ADDU; ex_wdata = 32'hCAFE_0001; ex_wreg = 1'b1;
        bus_ack = 1'b1; bus_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        check("rstbusy_req_dropped", {31'h0, bus_req}, 32'h0);
        check("rstbusy_stall", {31'h0, stallreq}, 32'h0);
        check("rstbusy_passthru", mem_wdata, 32'hCAFE_0001);
        @(posedge clk); #1;
        bus_ack = 1'b0;
        @(negedge clk);
        check("rstbusy_late_ack_req", {31'h0, bus_req}, 32'h0);
        check("rstbusy_late_ack_stall", {31'h0, stallreq}, 32'h0);
        check("rstbusy_late_ack_wdata", mem_wdata, 32'hCAFE_0001);
        check("rstbusy_no_timeout", {31'h0, bus_timeout}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_lsu.md
Name: mem_lsu

Overview:
- MEM stage of the 5-stage MIPS32 pipeline. Sits between ex_mem and mem_wb and feeds mem_wb's mem_* inputs.
- Non-memory instructions pass straight through combinationally.
- Loads and stores run a single-outstanding req/ack data-bus transaction. While the transaction is open, the block raises stallreq to ctrl, which drives stall=6'b011111. That holds ex_mem and makes mem_wb insert a bubble.

Parameters:
- TIMEOUT, 255, bus wait cycles before a transaction is abandoned; 0 disables the timeout.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high (`RstEnable)
- ex_wd  in  5  destination register from ex_mem
- ex_wreg  in  1  register write enable
- ex_wdata  in  32  ALU result
- ex_hi  in  32  HI value
- ex_lo  in  32  LO value
- ex_whilo  in  1  HI/LO write enable
- ex_aluop  in  8  operation code
- ex_mem_addr  in  32  effective address
- ex_reg2  in  32  store data
- mem_wd, mem_wreg, mem_wdata, mem_hi, mem_lo, mem_whilo  out  5/1/32/32/32/1  to mem_wb
- stallreq  out  1  stall request to ctrl
- bus_req  out  1  transaction request (registered)
- bus_we  out  1  1 = write (registered)
- bus_addr  out  32  word-aligned address, {addr[31:2],2'b00} (registered)
- bus_sel  out  4  byte-lane enables, bit3 = bits[31:24] (registered)
- bus_wdata  out  32  lane-replicated store data (registered)
- bus_rdata  in  32  read data
- bus_ack  in  1  one-cycle completion strobe
- bus_timeout  out  1  one-cycle pulse when a transaction is abandoned

Behaviour:
- Memory ops (define.v codes): LB 11100000, LBU 11100100, LH 11100001, LHU 11100101, LW 11100011, SB 11101000, SH 11101001, SW 11101011. All other codes are non-memory.
- Byte order is big-endian: addr[1:0]=00 selects lane [31:24].
- Alignment: halfword ops ignore addr[0]; word ops ignore addr[1:0].
- Reset values: all bus_* outputs 0, state IDLE, timeout counter 0, latched data 0.
- While rst is high, stallreq=0 and the mem_* outputs are the pass-through values.
- mem_hi, mem_lo, mem_whilo and mem_wd always equal the ex_* inputs.
- mem_wreg equals ex_wreg, except it is forced to 0 on a timed-out load.
- States:
  - IDLE
    - Non-memory op: stallreq=0, mem_wdata=ex_wdata.
    - Memory op: stallreq=1; next edge registers bus_req=1, bus_we, bus_addr, bus_sel, bus_wdata and moves to BUSY.
  - BUSY
    - stallreq=1; bus outputs held stable; counter increments every cycle.
    - On bus_ack: clear bus_req, latch bus_rdata, move to DONE.
    - If no ack and the counter reaches TIMEOUT-1 (TIMEOUT>0): clear bus_req, pulse bus_timeout, latch data 0, set the timed-out flag, move to DONE.
  - DONE
    - stallreq=0; mem_wdata is the aligned, extended latched data for loads and ex_wdata for stores.
    - The next edge returns to IDLE and the pipeline advances.
- Minimum stall with a zero-wait slave (ack in the first BUSY cycle) is 2 cycles.
- Load extension: LB/LH sign-extend the selected lane; LBU/LHU zero-extend.
- bus_sel: SB gives a one-hot lane; SH gives 1100 or 0011; SW gives 1111. Loads use the same sel pattern as the matching store size.
- bus_wdata: SB replicates reg2[7:0] ×4; SH replicates reg2[15:0] ×2; SW uses reg2.
- bus_ack is ignored in IDLE and DONE.
- A memory op directly following a memory op starts from IDLE normally, with no lost cycle beyond DONE→IDLE.
- Reset in BUSY or DONE: return to IDLE, bus_req drops on the same edge, latched data is cleared, and any late ack is ignored.

Decomposition:
- Operation codes, `RstEnable, `ZeroWord and bus widths live in the shared define.v. Add macros for the FSM state encodings (IDLE=2'b00, BUSY=2'b01, DONE=2'b10).
- One combinational sub-module, mem_align: inputs aluop, addr[1:0], reg2, rdata; outputs sel, replicated wdata, extended load data. It is shared by the request path and the DONE path.

Test Plan:
- ADDU, ex_wdata=0x12345678, wreg=1, wd=5 -> same cycle: mem_wdata=0x12345678, mem_wreg=1, stallreq=0, bus_req stays 0.
- LB, addr=0x00000103, slave ack in first BUSY cycle with rdata=0xAABBCC80:
  - stallreq high for 2 cycles.
  - bus_addr=0x00000100, bus_sel=0001.
  - DONE: mem_wdata=0xFFFFFF80.
- LHU, addr=0x2, rdata=0x1234F00D, ack after 3 wait cycles -> bus_sel=0011, stallreq high 5 cycles, mem_wdata=0x0000F00D.
- SB, addr=0x1, reg2=0x000000A5 -> bus_we=1, bus_sel=0100, bus_wdata=0xA5A5A5A5; mem_wreg follows ex_wreg(=0).
- LW with TIMEOUT=4 and no ack:
  - bus_timeout pulses after 4 BUSY cycles.
  - DONE: mem_wreg=0, mem_wdata=0.
  - Back in IDLE after one more cycle.
- LW in BUSY, rst asserted for 1 cycle, then ack arrives -> bus_req=0 and state IDLE after the reset edge; the ack is ignored and stallreq=0 for the following non-memory op.
